// File: rtl/cpu_pkg.sv
// Shared run-state type, default HLT opcode and trace-entry packing for the cpu run monitor.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } run_state_t;

  localparam logic [7:0] HLT_OP = 8'h0A;

  // Packs {pc, inst} with inst in the low inst_w bits; callers keep the low PC_W+INST_W bits.
  function automatic logic [63:0] trace_entry(input logic [31:0] pc,
                                              input logic [31:0] inst,
                                              input int unsigned inst_w);
    trace_entry = ({32'd0, pc} << inst_w) | {32'd0, inst};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word fall-through trace buffer with wrap-bit pointers and a sticky overflow flag.
// Full-buffer pushes overwrite the oldest entry when CPU_TRACE_WRAP_EN is defined, else are dropped.
module trace_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         overflow_q, overflow_d;
  logic         empty_s, full_s, pop_ok_s, mem_we_s;
  logic [W-1:0] mem_q [DEPTH];

  // Pointer and overflow next-state; clr discards any same-edge push or pop.
  always_comb begin
    empty_s    = (wr_ptr_q == rd_ptr_q);
    full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok_s   = pop && !empty_s;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    mem_we_s   = 1'b0;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push) begin
        if (!full_s || pop_ok_s) begin
          mem_we_s = 1'b1;
          wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end else begin
          overflow_d = 1'b1;
`ifdef CPU_TRACE_WRAP_EN
          mem_we_s   = 1'b1;
          wr_ptr_d   = wr_ptr_q + (AW+1)'(1);
          rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
`else
          mem_we_s   = 1'b0;
          wr_ptr_d   = wr_ptr_q;
`endif
        end
      end else begin
        mem_we_s = 1'b0;
      end
    end
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata    = mem_q[rd_ptr_q[AW-1:0]];
  assign empty    = empty_s;
  assign full     = full_s;
  assign overflow = overflow_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control FSM, cycle/instruction counters and output capture that sit beside the cpu core.
// Trace overflow policy (overwrite vs drop) is selected by CPU_TRACE_WRAP_EN inside trace_fifo.
module cpu_run_monitor
  import cpu_pkg::*;
#(
  parameter int                INST_W         = 8,
  parameter int                PC_W           = 4,
  parameter int                DATA_W         = 8,
  parameter logic [INST_W-1:0] HLT_OPCODE     = INST_W'(HLT_OP),
  parameter int                TIMEOUT_CYCLES = 150,
  parameter int                TRACE_DEPTH    = 16
) (
  input  logic                                  clk,
  input  logic                                  clear_n,
  input  logic                                  start,
  input  logic                                  inst_valid,
  input  logic [INST_W-1:0]                     inst,
  input  logic [PC_W-1:0]                       pc,
  input  logic                                  out_valid,
  input  logic [DATA_W-1:0]                     out_data,
  output logic                                  running,
  output logic                                  cpu_hold,
  output logic                                  halted,
  output logic                                  timed_out,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]   cycle_count,
  output logic [15:0]                           inst_count,
  output logic [DATA_W-1:0]                     last_out,
  input  logic                                  trace_rd_en,
  output logic [PC_W+INST_W-1:0]                trace_rd_data,
  output logic                                  trace_empty,
  output logic                                  trace_full,
  output logic                                  trace_overflow
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
  localparam int TW    = PC_W + INST_W;

  run_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [15:0]       inst_cnt_q, inst_cnt_d;
  logic              halted_q, halted_d;
  logic              timed_out_q, timed_out_d;
  logic [DATA_W-1:0] last_out_q, last_out_d;
  logic              running_q, running_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              fifo_clr_s, fifo_push_s, fifo_pop_s;
  logic [TW-1:0]     fifo_wdata_s;

  // FSM next-state, counters and capture; start overrides everything else on its edge.
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    inst_cnt_d  = inst_cnt_q;
    halted_d    = halted_q;
    timed_out_d = timed_out_q;
    last_out_d  = last_out_q;
    fifo_clr_s  = 1'b0;
    fifo_push_s = 1'b0;
    fifo_pop_s  = 1'b0;
    if (start) begin
      state_d     = RUN;
      cycle_d     = '0;
      inst_cnt_d  = '0;
      halted_d    = 1'b0;
      timed_out_d = 1'b0;
      fifo_clr_s  = 1'b1;
    end else begin
      fifo_pop_s = trace_rd_en;
      case (state_q)
        RUN: begin
          cycle_d = cycle_q + CNT_W'(1);
          if (out_valid) begin
            last_out_d = out_data;
          end else begin
            last_out_d = last_out_q;
          end
          if (inst_valid) begin
            fifo_push_s = 1'b1;
            if (inst_cnt_q != 16'hFFFF) begin
              inst_cnt_d = inst_cnt_q + 16'd1;
            end else begin
              inst_cnt_d = inst_cnt_q;
            end
          end else begin
            fifo_push_s = 1'b0;
          end
          // HLT outranks a coincident budget expiry.
          if (inst_valid && (inst == HLT_OPCODE)) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else if (cycle_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d     = TIMEOUT;
            timed_out_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        IDLE, HALTED, TIMEOUT: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    running_d  = (state_d == RUN);
    cpu_hold_d = (state_d != RUN);
  end

  // Run-control registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      cycle_q     <= '0;
      inst_cnt_q  <= '0;
      halted_q    <= 1'b0;
      timed_out_q <= 1'b0;
      last_out_q  <= '0;
      running_q   <= 1'b0;
      cpu_hold_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      inst_cnt_q  <= inst_cnt_d;
      halted_q    <= halted_d;
      timed_out_q <= timed_out_d;
      last_out_q  <= last_out_d;
      running_q   <= running_d;
      cpu_hold_q  <= cpu_hold_d;
    end
  end

  assign fifo_wdata_s = TW'(trace_entry(32'(pc), 32'(inst), INST_W));

  trace_fifo #(
    .W     (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk      (clk),
    .clear_n  (clear_n),
    .clr      (fifo_clr_s),
    .push     (fifo_push_s),
    .pop      (fifo_pop_s),
    .wdata    (fifo_wdata_s),
    .rdata    (trace_rd_data),
    .empty    (trace_empty),
    .full     (trace_full),
    .overflow (trace_overflow)
  );

  assign running     = running_q;
  assign cpu_hold    = cpu_hold_q;
  assign halted      = halted_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_q;
  assign inst_count  = inst_cnt_q;
  assign last_out    = last_out_q;

endmodule
